// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- front-end hazard / flush / freeze sequencer.
//
// Tracks in-flight register writes with one saturating counter per register.
// An ID instruction is held (stall_if/stall_id) while a source is pending, or
// while its destination counter is already at max. For FLUSH_CYC cycles after
// a redirect, the IF_ID register is bubbled. The whole front end freezes on
// ext_stall_i.
//
// Optional feature: define PIPE_HAZARD_CTRL_STAT_EN to build the stall and
// flush statistics counters. When it is undefined, both stat ports read 0.
//
// Ports:
//   clk, rst                  clock, async active-low reset
//   id_valid/re1/re2/raddr*   ID decode fields (sources)
//   id_we/id_waddr            ID destination
//   wb_we/wb_waddr            writeback retire port
//   redirect_i, ext_stall_i   EX redirect pulse, memory-busy freeze
//   stall_if, stall_id        hold PC / hold IF_ID
//   flush_id                  bubble IF_ID
//   issue_o                   ID instruction accepted into EX
//   busy_o                    any write in flight
//   err_o                     sticky retire-with-zero-count error
//   stat_stall_cnt/flush_cnt  statistics (0 unless STAT_EN)

// Per-register pending-write counter.
module pipe_hazard_ctrl_pend #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt
);
    localparam logic [PEND_W-1:0] PMAX = '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          cnt <= '0;
        else if (inc && !dec && cnt != PMAX) cnt <= cnt + 1'b1;
        else if (dec && !inc && cnt != '0)   cnt <= cnt - 1'b1;
    end
endmodule

module pipe_hazard_ctrl #(
    parameter int REG_NUM   = 32,
    parameter int RADDR_W   = 5,
    parameter int PEND_W    = 2,
    parameter int FLUSH_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic               id_re1,
    input  logic               id_re2,
    input  logic [RADDR_W-1:0] id_raddr1,
    input  logic [RADDR_W-1:0] id_raddr2,
    input  logic               id_we,
    input  logic [RADDR_W-1:0] id_waddr,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_waddr,
    input  logic               redirect_i,
    input  logic               ext_stall_i,
    output logic               stall_if,
    output logic               stall_id,
    output logic               flush_id,
    output logic               issue_o,
    output logic               busy_o,
    output logic               err_o,
    output logic [31:0]        stat_stall_cnt,
    output logic [31:0]        stat_flush_cnt
);
    localparam int              FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYC - 1);
    localparam logic [PEND_W-1:0] PMAX  = '1;

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_FREEZE} state_t;

    state_t                          state;
    logic [FC_W-1:0]                 fcnt;
    logic [REG_NUM-1:0][PEND_W-1:0]  pend;
    logic [REG_NUM-1:0]              inc_v, dec_v;
    logic                            hazard;

    // Hazard on a pending source, or on a destination whose counter is full.
    always_comb begin
        hazard = id_valid & (
                 (id_re1 & (id_raddr1 != '0) & (pend[id_raddr1] != '0)) |
                 (id_re2 & (id_raddr2 != '0) & (pend[id_raddr2] != '0)) |
                 (id_we  & (id_waddr  != '0) & (pend[id_waddr]  == PMAX)));
    end

    // Outputs are gated by rst so they drop as soon as reset asserts,
    // whatever the decode inputs are doing.
    assign flush_id = rst & (redirect_i | (state == S_FLUSH));
    assign stall_if = rst & ~flush_id & (ext_stall_i | hazard);
    assign stall_id = stall_if;
    assign issue_o  = rst & id_valid & ~flush_id & ~ext_stall_i & ~hazard;
    assign busy_o   = rst & (|pend);

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        inc_v[id_waddr] = issue_o & id_we;
        dec_v[wb_waddr] = wb_we & (pend[wb_waddr] != '0);
        inc_v[0] = 1'b0;
        dec_v[0] = 1'b0;
    end

    for (genvar r = 0; r < REG_NUM; r++) begin : g_pend
        if (r == 0) begin : g_x0
            assign pend[r] = '0;
        end else begin : g_reg
            pipe_hazard_ctrl_pend #(.PEND_W(PEND_W)) u_pend (
                .clk (clk),
                .rst (rst),
                .inc (inc_v[r]),
                .dec (dec_v[r]),
                .cnt (pend[r])
            );
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_o <= 1'b0;
        else if (wb_we && wb_waddr != '0 && pend[wb_waddr] == '0)
            err_o <= 1'b1;
    end

    // fcnt counts the remaining S_FLUSH cycles after the redirect cycle itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RUN;
            fcnt  <= '0;
        end else if (redirect_i) begin
            if (FLUSH_CYC > 1) begin
                state <= S_FLUSH;
                fcnt  <= FC_LOAD;
            end else begin
                state <= S_RUN;
                fcnt  <= '0;
            end
        end else if (state == S_FLUSH) begin
            fcnt <= fcnt - 1'b1;
            if (fcnt == FC_W'(1))
                state <= ext_stall_i ? S_FREEZE : S_RUN;
        end else begin
            state <= ext_stall_i ? S_FREEZE : S_RUN;
        end
    end

`ifdef PIPE_HAZARD_CTRL_STAT_EN
    logic [31:0] st_q, fl_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q <= '0;
            fl_q <= '0;
        end else begin
            if (hazard && !flush_id && !ext_stall_i) st_q <= st_q + 32'd1;
            if (flush_id)                            fl_q <= fl_q + 32'd1;
        end
    end
    assign stat_stall_cnt = st_q;
    assign stat_flush_cnt = fl_q;
`else
    assign stat_stall_cnt = 32'h0;
    assign stat_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a cycle-level reference model.
module tb_pipe_hazard_ctrl;
    localparam int FLUSH_CYC = 2;
    localparam int PMAX      = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_re1, id_re2, id_we, wb_we, redirect_i, ext_stall_i;
    logic [4:0] id_raddr1, id_raddr2, id_waddr, wb_waddr;
    logic       stall_if, stall_id, flush_id, issue_o, busy_o, err_o;
    logic [31:0] stat_stall_cnt, stat_flush_cnt;

    pipe_hazard_ctrl #(.REG_NUM(32), .RADDR_W(5), .PEND_W(2), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_re1(id_re1), .id_re2(id_re2),
        .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
        .id_we(id_we), .id_waddr(id_waddr),
        .wb_we(wb_we), .wb_waddr(wb_waddr),
        .redirect_i(redirect_i), .ext_stall_i(ext_stall_i),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
        .issue_o(issue_o), .busy_o(busy_o), .err_o(err_o),
        .stat_stall_cnt(stat_stall_cnt), .stat_flush_cnt(stat_flush_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pend[] holds in-flight writes per register, fl holds the
    // flush cycles still owed after the current one.
    int          pend[32];
    int          fl;
    bit          merr;
    int unsigned est, efl;

    always @(negedge clk) begin : model
        bit hz, fo, ex_st, ex_is, bz;
        int a1, a2, wa, wba;
        if (!rst) begin
            foreach (pend[i]) pend[i] = 0;
            fl = 0; merr = 0; est = 0; efl = 0;
            chk("m_rst_flush", {31'b0, flush_id}, 0);
            chk("m_rst_stall", {30'b0, stall_if, stall_id}, 0);
            chk("m_rst_issue", {31'b0, issue_o}, 0);
            chk("m_rst_busy",  {31'b0, busy_o}, 0);
            chk("m_rst_err",   {31'b0, err_o}, 0);
            chk("m_rst_sst",   stat_stall_cnt, 0);
            chk("m_rst_sfl",   stat_flush_cnt, 0);
        end else begin
            a1 = int'(id_raddr1); a2 = int'(id_raddr2);
            wa = int'(id_waddr);  wba = int'(wb_waddr);
            hz = id_valid && ((id_re1 && a1 != 0 && pend[a1] != 0) ||
                              (id_re2 && a2 != 0 && pend[a2] != 0) ||
                              (id_we  && wa != 0 && pend[wa] == PMAX));
            fo    = redirect_i || (fl > 0);
            ex_st = !fo && (ext_stall_i || hz);
            ex_is = id_valid && !fo && !ext_stall_i && !hz;
            bz = 0;
            foreach (pend[i]) if (pend[i] != 0) bz = 1;
            chk("m_flush",    {31'b0, flush_id}, {31'b0, fo});
            chk("m_stall_if", {31'b0, stall_if}, {31'b0, ex_st});
            chk("m_stall_id", {31'b0, stall_id}, {31'b0, ex_st});
            chk("m_issue",    {31'b0, issue_o},  {31'b0, ex_is});
            chk("m_busy",     {31'b0, busy_o},   {31'b0, bz});
            chk("m_err",      {31'b0, err_o},    {31'b0, merr});
`ifdef PIPE_HAZARD_CTRL_STAT_EN
            chk("m_sst", stat_stall_cnt, est);
            chk("m_sfl", stat_flush_cnt, efl);
            if (hz && !fo && !ext_stall_i) est++;
            if (fo) efl++;
`else
            chk("m_sst", stat_stall_cnt, 0);
            chk("m_sfl", stat_flush_cnt, 0);
`endif
            // state after the coming posedge
            if (redirect_i)  fl = FLUSH_CYC - 1;
            else if (fl > 0) fl--;
            if (wb_we && wba != 0) begin
                if (pend[wba] == 0) merr = 1;
                else                pend[wba]--;
            end
            if (ex_is && id_we && wa != 0) pend[wa]++;
        end
    end

    task automatic idle();
        id_valid = 0; id_re1 = 0; id_re2 = 0; id_we = 0;
        id_raddr1 = 0; id_raddr2 = 0; id_waddr = 0;
        wb_we = 0; wb_waddr = 0; redirect_i = 0; ext_stall_i = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic idi(input logic v, input logic r1, input logic [4:0] a1,
                       input logic w, input logic [4:0] wa);
        id_valid = v; id_re1 = r1; id_raddr1 = a1; id_re2 = 0; id_raddr2 = 0;
        id_we = w; id_waddr = wa;
    endtask

    task automatic wb(input logic e, input logic [4:0] a);
        wb_we = e; wb_waddr = a;
    endtask

    initial begin
        rst = 0;
        idle();
        #3;
        chk("rst_stall_if", {31'b0, stall_if}, 0);
        chk("rst_flush",    {31'b0, flush_id}, 0);
        chk("rst_issue",    {31'b0, issue_o}, 0);
        chk("rst_busy_err", {30'b0, busy_o, err_o}, 0);
        cyc(); rst = 1;

        // 1) RAW on x5, cleared one cycle after the writeback
        cyc(); idi(1, 0, 0, 1, 5);     #1 chk("t1_issue_w5", {31'b0, issue_o}, 1);
        cyc(); idi(1, 1, 5, 0, 0);     #1 chk("t1_stall", {30'b0, stall_if, stall_id}, 2'b11);
                                           chk("t1_noissue", {31'b0, issue_o}, 0);
        cyc();                         #1 chk("t1_stall2", {31'b0, stall_if}, 1);
        cyc(); wb(1, 5);               #1 chk("t1_nobypass", {31'b0, stall_if}, 1);
        cyc(); wb(0, 0);               #1 chk("t1_release", {31'b0, issue_o}, 1);
        cyc(); idle();                 #1 chk("t1_idle_busy", {31'b0, busy_o}, 0);

        // 2) x0 is never tracked
        cyc(); idi(1, 1, 0, 1, 0);     #1 chk("t2_issue", {31'b0, issue_o}, 1);
        cyc();                         #1 chk("t2_issue2", {31'b0, issue_o}, 1);
                                           chk("t2_busy", {31'b0, busy_o}, 0);
        cyc(); idle();

        // 3) x7 saturates at 3 writes in flight
        for (int i = 0; i < 3; i++) begin
            cyc(); idi(1, 0, 0, 1, 7); #1 chk("t3_issue", {31'b0, issue_o}, 1);
        end
        cyc();                         #1 chk("t3_sat_stall", {31'b0, stall_if}, 1);
        cyc(); wb(1, 7);               #1 chk("t3_sat_stall2", {31'b0, stall_if}, 1);
        cyc(); wb(0, 0);               #1 chk("t3_sat_issue", {31'b0, issue_o}, 1);
        cyc(); idle(); wb(1, 7);
        cyc();
        cyc();
        cyc(); wb(0, 0);               #1 chk("t3_drained", {31'b0, busy_o}, 0);
                                           chk("t3_noerr", {31'b0, err_o}, 0);

        // 4) redirect over a pending hazard: flush wins for FLUSH_CYC cycles
        cyc(); idi(1, 0, 0, 1, 4);     #1 chk("t4_issue_w4", {31'b0, issue_o}, 1);
        cyc(); idi(1, 1, 4, 0, 0); redirect_i = 1;
                                       #1 chk("t4_flush0", {29'b0, flush_id, stall_if, issue_o}, 3'b100);
        cyc(); redirect_i = 0;         #1 chk("t4_flush1", {29'b0, flush_id, stall_if, issue_o}, 3'b100);
        cyc();                         #1 chk("t4_after", {29'b0, flush_id, stall_if, issue_o}, 3'b010);
        cyc(); wb(1, 4);               #1 chk("t4_stall_wb", {31'b0, stall_if}, 1);
        cyc(); wb(0, 0);               #1 chk("t4_issue", {31'b0, issue_o}, 1);
        cyc(); idle();
        // back-to-back redirects reload the window
        cyc(); redirect_i = 1;
        cyc();                         #1 chk("t4_reload0", {31'b0, flush_id}, 1);
        cyc(); redirect_i = 0;         #1 chk("t4_reload1", {31'b0, flush_id}, 1);
        cyc();                         #1 chk("t4_reload_end", {31'b0, flush_id}, 0);

        // 5) freeze while writeback retires x3
        cyc(); idi(1, 0, 0, 1, 3);     #1 chk("t5_issue_w3", {31'b0, issue_o}, 1);
        cyc(); idi(1, 0, 0, 0, 0); ext_stall_i = 1; wb(1, 3);
                                       #1 chk("t5_frz0", {29'b0, stall_if, issue_o, busy_o}, 3'b101);
        cyc(); wb(0, 0);               #1 chk("t5_frz1", {29'b0, stall_if, issue_o, busy_o}, 3'b100);
        cyc();                         #1 chk("t5_frz2", {31'b0, stall_if}, 1);
        cyc(); ext_stall_i = 0;        #1 chk("t5_thaw", {30'b0, stall_if, issue_o}, 2'b01);
        cyc(); idle();

        // 6) retire with zero count, then reset mid-run
        cyc(); idi(1, 0, 0, 1, 2);     #1 chk("t6_issue_w2", {31'b0, issue_o}, 1);
        cyc(); idle(); wb(1, 9);       #1 chk("t6_err_pre", {31'b0, err_o}, 0);
        cyc(); wb(0, 0);               #1 chk("t6_err_set", {31'b0, err_o}, 1);
        cyc();                         #1 chk("t6_err_sticky", {30'b0, err_o, busy_o}, 2'b11);
        cyc(); redirect_i = 1; idi(1, 0, 0, 0, 0);
                                       #1 chk("t6_pre_rst_flush", {31'b0, flush_id}, 1);
        rst = 0;
        #1 chk("t6_async_rst", {26'b0, stall_if, stall_id, flush_id, issue_o, busy_o, err_o}, 0);
        cyc(); idle(); rst = 1;        #1 chk("t6_after_rst", {30'b0, err_o, busy_o}, 0);
        cyc(); idi(1, 1, 2, 0, 0);     #1 chk("t6_sb_cleared", {31'b0, issue_o}, 1);
        cyc(); idle();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
